// File: rtl/codma_pkg.sv
// Shared types and constants for the codma task scheduler: FSM state encoding,
// descriptor geometry and the descriptor-pointer legality check.
package codma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DISPATCH  = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_COMPLETE  = 2'd3
  } codma_state_e;

  localparam int CODMA_DESC_BYTES    = 16;
  localparam int CODMA_MEM_BYTES_DEF = 256;

  // A descriptor must be 8-byte aligned and lie entirely inside the memory.
  function automatic logic codma_ptr_valid(input logic [31:0] ptr, input int mem_bytes);
    logic [32:0] end_addr;
    end_addr = {1'b0, ptr} + 33'(CODMA_DESC_BYTES);
    return (ptr[2:0] == 3'd0) && (end_addr <= 33'(mem_bytes));
  endfunction

endpackage

// File: rtl/codma_rr_arbiter.sv
// Combinational round-robin arbiter: the requester at ptr_i has the highest
// priority, then ptr_i+1, ... wrapping modulo NUM_REQ. One-hot grant out.
module codma_rr_arbiter
  import codma_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o
);

  localparam int IDW = $clog2(NUM_REQ);

  // Walk the requesters starting at the priority pointer; first hit wins.
  always_comb begin
    logic           found;
    int             s;
    logic [IDW-1:0] idx;
    grant_o = '0;
    found   = 1'b0;
    s       = 0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s = int'(ptr_i) + i;
      if (s >= NUM_REQ) begin
        s = s - NUM_REQ;
      end else begin
        s = s;
      end
      idx = IDW'(s);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/codma_task_scheduler.sv
// Shares one codma core between NUM_REQ requesters with round-robin dispatch.
// Optional watchdog on the core: define CODMA_SCHED_TIMEOUT_EN to build it in.
module codma_task_scheduler
  import codma_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MEM_BYTES      = CODMA_MEM_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_start_i,
  input  logic [NUM_REQ-1:0][31:0]      req_task_ptr_i,
  input  logic [NUM_REQ-1:0][31:0]      req_status_ptr_i,
  output logic [NUM_REQ-1:0]            req_ack_o,
  output logic [NUM_REQ-1:0]            req_done_o,
  output logic [NUM_REQ-1:0]            req_error_o,
  output logic                          dma_start_o,
  output logic [31:0]                   dma_task_ptr_o,
  output logic [31:0]                   dma_status_ptr_o,
  input  logic                          dma_done_i,
  input  logic                          dma_error_i,
  output logic                          dma_abort_o,
  output logic                          sched_busy_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o
);

  localparam int             IDW     = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  codma_state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]           pending_q, pending_d;
  logic [NUM_REQ-1:0][31:0]     task_ptr_q, task_ptr_d;
  logic [NUM_REQ-1:0][31:0]     stat_ptr_q, stat_ptr_d;
  logic [IDW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]               grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]           ack_q, ack_d;
  logic [NUM_REQ-1:0]           done_q, done_d;
  logic [NUM_REQ-1:0]           err_q, err_d;
  logic                         start_q, start_d;
  logic [31:0]                  dma_task_q, dma_task_d;
  logic [31:0]                  dma_stat_q, dma_stat_d;
  logic [NUM_REQ-1:0]           grant_oh_s;
  logic [IDW-1:0]               grant_idx_s;

  // Zero is not a usable watchdog limit.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_must_be_positive
  end

`ifdef CODMA_SCHED_TIMEOUT_EN
  localparam int             WDW     = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0]            wdog_q, wdog_d;
  logic                      abort_q, abort_d;
`endif

  codma_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (pending_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_oh_s)
  );

  // One-hot grant to binary index.
  always_comb begin
    grant_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_idx_s = grant_idx_s | (grant_oh_s[i] ? IDW'(i) : '0);
    end
  end

  // Submission capture and scheduler FSM next-state/output logic.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    task_ptr_d = task_ptr_q;
    stat_ptr_d = stat_ptr_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    dma_task_d = dma_task_q;
    dma_stat_d = dma_stat_q;
    ack_d      = '0;
    done_d     = '0;
    err_d      = '0;
    start_d    = 1'b0;
`ifdef CODMA_SCHED_TIMEOUT_EN
    wdog_d     = wdog_q;
    abort_d    = 1'b0;
`endif

    // A requester with a task already outstanding (including the grantee) is ignored.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_start_i[i] && !pending_q[i]) begin
        pending_d[i]  = 1'b1;
        task_ptr_d[i] = req_task_ptr_i[i];
        stat_ptr_d[i] = req_status_ptr_i[i];
        ack_d[i]      = 1'b1;
      end else begin
        ack_d[i] = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          grant_id_d = grant_idx_s;
          if (codma_ptr_valid(task_ptr_q[grant_idx_s], MEM_BYTES)) begin
            dma_task_d = task_ptr_q[grant_idx_s];
            dma_stat_d = stat_ptr_q[grant_idx_s];
            start_d    = 1'b1;
            state_d    = ST_DISPATCH;
          end else begin
            done_d[grant_idx_s] = 1'b1;
            err_d[grant_idx_s]  = 1'b1;
            state_d             = ST_COMPLETE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        state_d = ST_WAIT_DONE;
`ifdef CODMA_SCHED_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      ST_WAIT_DONE: begin
        if (dma_done_i) begin
          done_d[grant_id_q] = 1'b1;
          err_d[grant_id_q]  = dma_error_i;
          state_d            = ST_COMPLETE;
`ifdef CODMA_SCHED_TIMEOUT_EN
        end else if (wdog_q == WD_LAST) begin
          // Abort goes out with the error completion; a coincident done beats it above.
          abort_d            = 1'b1;
          done_d[grant_id_q] = 1'b1;
          err_d[grant_id_q]  = 1'b1;
          state_d            = ST_COMPLETE;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
`else
        end else begin
          state_d = ST_WAIT_DONE;
        end
`endif
      end
      ST_COMPLETE: begin
        pending_d[grant_id_q] = 1'b0;
        rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IDW'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops every pending task silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      task_ptr_q <= '0;
      stat_ptr_q <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      start_q    <= 1'b0;
      dma_task_q <= 32'd0;
      dma_stat_q <= 32'd0;
`ifdef CODMA_SCHED_TIMEOUT_EN
      wdog_q     <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      task_ptr_q <= task_ptr_d;
      stat_ptr_q <= stat_ptr_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      start_q    <= start_d;
      dma_task_q <= dma_task_d;
      dma_stat_q <= dma_stat_d;
`ifdef CODMA_SCHED_TIMEOUT_EN
      wdog_q     <= wdog_d;
      abort_q    <= abort_d;
`endif
    end
  end

  assign req_ack_o        = ack_q;
  assign req_done_o       = done_q;
  assign req_error_o      = err_q;
  assign dma_start_o      = start_q;
  assign dma_task_ptr_o   = dma_task_q;
  assign dma_status_ptr_o = dma_stat_q;
  assign grant_id_o       = grant_id_q;
  assign sched_busy_o     = (state_q != ST_IDLE);
`ifdef CODMA_SCHED_TIMEOUT_EN
  assign dma_abort_o      = abort_q;
`else
  assign dma_abort_o      = 1'b0;
`endif

endmodule
